// File: rtl/id_stage_reg.sv
// id_stage_reg: RV64I instruction-decode stage feeding the ID/EX pipeline register.
//
// Slices the fetched instruction into register-file read indices, decodes the
// main control and sign-extended immediate, and captures them with the operands
// into the ID/EX register under a valid/ready handshake. A load-use hazard
// against the instruction in ID/EX inserts one bubble; flush kills ID/EX.
//
// Optional feature (compile-time macro ID_WB_BYPASS_EN): when defined, each
// captured operand takes wb_WriteData instead of the register-file data if
// write-back targets the same non-zero register in that cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   if_valid/if_ready   fetch-side handshake; if_instr, if_pc instruction and PC
//   rs1, rs2            combinational read indices to the register file
//   rf_ReadData1/2      register-file read data
//   wb_RegWrite/rd/WriteData  snooped write-back port (bypass only)
//   flush               kill ID/EX contents
//   ex_ready            execute stage accepts
//   id_*                registered ID/EX contents (valid, PC, operands, imm, rd,
//                       funct, control bits, ALU op class)
module id_stage_reg #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [AW-1:0]   rs1,
  output logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] rf_ReadData1,
  input  logic [XLEN-1:0] rf_ReadData2,
  input  logic            wb_RegWrite,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_WriteData,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_ReadData1,
  output logic [XLEN-1:0] id_ReadData2,
  output logic [XLEN-1:0] id_imm,
  output logic [AW-1:0]   id_rd,
  output logic [3:0]      id_funct,
  output logic            id_RegWrite,
  output logic            id_MemRead,
  output logic            id_MemWrite,
  output logic            id_Branch,
  output logic            id_ALUSrc,
  output logic            id_MemtoReg,
  output logic [1:0]      id_ALUOp
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic            w_reg_write, w_mem_read, w_mem_write, w_branch, w_alu_src, w_mem_to_reg;
  logic [1:0]      w_alu_op;
  logic [XLEN-1:0] w_imm;
  logic            w_uses_rs1, w_uses_rs2;
  logic            w_hazard, w_advance;
  logic [XLEN-1:0] w_op1, w_op2;

  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_rd1, r_rd2, r_imm;
  logic [AW-1:0]   r_rd;
  logic [3:0]      r_funct;
  logic            r_reg_write, r_mem_read, r_mem_write, r_branch, r_alu_src, r_mem_to_reg;
  logic [1:0]      r_alu_op;

  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_op     = 2'b00;
    w_imm        = '0;
    w_uses_rs1   = 1'b0;
    w_uses_rs2   = 1'b0;
    case (if_instr[6:0])
      OpR: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OpImm: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
        w_imm       = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
        w_uses_rs1  = 1'b1;
      end
      OpLoad: begin
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_imm        = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
        w_uses_rs1   = 1'b1;
      end
      OpStore: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_imm       = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OpBranch: begin
        w_branch   = 1'b1;
        w_alu_op   = 2'b01;
        w_imm      = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      default: ;  // unknown opcode passes through as a NOP
    endcase
  end

  // Load in ID/EX whose result is needed now; x0 is never a real dependency.
  assign w_hazard = if_valid & r_valid & r_mem_read & (r_rd != '0) &
                    ((w_uses_rs1 & (r_rd == rs1)) | (w_uses_rs2 & (r_rd == rs2)));
  assign w_advance = ~r_valid | ex_ready;
  assign if_ready  = w_advance & ~w_hazard & ~flush;

`ifdef ID_WB_BYPASS_EN
  // Register file has no write-before-read, so forward a same-cycle write-back.
  assign w_op1 = (wb_RegWrite && (wb_rd != '0) && (wb_rd == rs1)) ? wb_WriteData : rf_ReadData1;
  assign w_op2 = (wb_RegWrite && (wb_rd != '0) && (wb_rd == rs2)) ? wb_WriteData : rf_ReadData2;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_RegWrite, wb_rd, wb_WriteData};
  assign w_op1 = rf_ReadData1;
  assign w_op2 = rf_ReadData2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rd         <= '0;
      r_funct      <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_op     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance && w_hazard) begin
      r_valid <= 1'b0;  // bubble; fetch holds the dependent instruction
    end else if (w_advance) begin
      r_valid <= if_valid;
      if (if_valid) begin
        r_pc         <= if_pc;
        r_rd1        <= w_op1;
        r_rd2        <= w_op2;
        r_imm        <= w_imm;
        r_rd         <= if_instr[11:7];
        r_funct      <= {if_instr[30], if_instr[14:12]};
        r_reg_write  <= w_reg_write;
        r_mem_read   <= w_mem_read;
        r_mem_write  <= w_mem_write;
        r_branch     <= w_branch;
        r_alu_src    <= w_alu_src;
        r_mem_to_reg <= w_mem_to_reg;
        r_alu_op     <= w_alu_op;
      end
    end
  end

  assign id_valid     = r_valid;
  assign id_pc        = r_pc;
  assign id_ReadData1 = r_rd1;
  assign id_ReadData2 = r_rd2;
  assign id_imm       = r_imm;
  assign id_rd        = r_rd;
  assign id_funct     = r_funct;
  assign id_RegWrite  = r_reg_write;
  assign id_MemRead   = r_mem_read;
  assign id_MemWrite  = r_mem_write;
  assign id_Branch    = r_branch;
  assign id_ALUSrc    = r_alu_src;
  assign id_MemtoReg  = r_mem_to_reg;
  assign id_ALUOp     = r_alu_op;

endmodule

// File: tb/tb_id_stage_reg.sv
module tb_id_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [3:0]  funct;
    logic        rw, mr, mw, br, as, m2r;
    logic [1:0]  aluop;
  } idex_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic [63:0] if_pc = '0;
  logic [4:0]  rs1, rs2;
  logic [63:0] rf_ReadData1 = '0, rf_ReadData2 = '0;
  logic        wb_RegWrite = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_WriteData = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;
  logic        id_valid;
  logic [63:0] id_pc, id_ReadData1, id_ReadData2, id_imm;
  logic [4:0]  id_rd;
  logic [3:0]  id_funct;
  logic        id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc, id_MemtoReg;
  logic [1:0]  id_ALUOp;

  id_stage_reg dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .rs1(rs1), .rs2(rs2),
    .rf_ReadData1(rf_ReadData1), .rf_ReadData2(rf_ReadData2),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_WriteData(wb_WriteData),
    .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2), .id_imm(id_imm),
    .id_rd(id_rd), .id_funct(id_funct), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
    .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp)
  );

  always #5 clk = ~clk;

  idex_t obs;
  assign obs = {id_valid, id_pc, id_ReadData1, id_ReadData2, id_imm, id_rd, id_funct,
                id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc, id_MemtoReg,
                id_ALUOp};

  int    n_chk = 0;
  int    n_err = 0;
  idex_t m = '0;       // expected ID/EX contents
  logic  last_rdy;     // DUT if_ready sampled in the last tick
  logic  last_acc;     // model: instruction accepted in the last tick

  task automatic check(input string tag, input logic [399:0] o, input logic [399:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Sign-extend the low n bits of v: values with the top bit set are negative.
  function automatic logic [63:0] sext(input int n, input logic [63:0] v);
    return (v >= (64'd1 << (n - 1))) ? v - (64'd1 << n) : v;
  endfunction

  function automatic logic uses1(input logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
  endfunction

  function automatic logic uses2(input logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [63:0] operand(input logic [4:0] r, input logic [63:0] rf);
`ifdef ID_WB_BYPASS_EN
    if (wb_RegWrite && wb_rd != 0 && wb_rd == r) return wb_WriteData;
`endif
    return rf;
  endfunction

  function automatic idex_t decode(input logic [31:0] ins, input logic [63:0] pc);
    idex_t d = '0;
    d.valid = 1'b1;
    d.pc    = pc;
    d.rd1   = operand(ins[19:15], rf_ReadData1);
    d.rd2   = operand(ins[24:20], rf_ReadData2);
    d.rd    = ins[11:7];
    d.funct = {ins[30], ins[14:12]};
    case (ins[6:0])
      7'h33: begin d.rw = 1; d.aluop = 2; end
      7'h13: begin d.as = 1; d.rw = 1; d.aluop = 2; d.imm = sext(12, 64'(ins[31:20])); end
      7'h03: begin
        d.as = 1; d.m2r = 1; d.rw = 1; d.mr = 1;
        d.imm = sext(12, 64'(ins[31:20]));
      end
      7'h23: begin
        d.as = 1; d.mw = 1;
        d.imm = sext(12, 64'(ins[31:25]) * 32 + 64'(ins[11:7]));
      end
      7'h63: begin
        d.br = 1; d.aluop = 1;
        d.imm = sext(13, 64'(ins[31]) * 4096 + 64'(ins[7]) * 2048 +
                         64'(ins[30:25]) * 32 + 64'(ins[11:8]) * 2);
      end
      default: ;
    endcase
    return d;
  endfunction

  // One clock: check the combinational outputs, advance the model, check ID/EX.
  task automatic tick();
    logic  haz, adv, rdy;
    idex_t nx;
    #1;
    haz = if_valid && m.valid && m.mr && m.rd != 0 &&
          ((uses1(if_instr) && m.rd == if_instr[19:15]) ||
           (uses2(if_instr) && m.rd == if_instr[24:20]));
    adv = !m.valid || ex_ready;
    rdy = adv && !haz && !flush;
    check("if_ready", 400'(if_ready), 400'(rdy));
    check("rs1", 400'(rs1), 400'(if_instr[19:15]));
    check("rs2", 400'(rs2), 400'(if_instr[24:20]));
    last_rdy = if_ready;
    last_acc = rdy && if_valid;
    nx = m;
    if (flush) nx.valid = 1'b0;
    else if (adv && haz) nx.valid = 1'b0;
    else if (adv) begin
      if (if_valid) nx = decode(if_instr, if_pc);
      else nx.valid = 1'b0;
    end
    @(posedge clk);
    #1;
    m = nx;
    check("idex", 400'(obs), 400'(m));
  endtask

  // Present an instruction until the model says it was taken (bounded).
  task automatic accept(input logic [31:0] ins, input logic [63:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    last_acc = 1'b0;
    for (int i = 0; i < 6 && !last_acc; i++) tick();
    check("accept", 400'(last_rdy), 400'(1'b1));
  endtask

  initial begin
    #2;
    check("reset_valid", 400'(id_valid), 400'(0));
    check("reset_all", 400'(obs), 400'(0));
    #4 reset = 1'b1;  // released between edges
    @(posedge clk);
    #1;
    tick();

    // Decode sequence with full throughput where no hazard exists.
    rf_ReadData1 = 64'h11; rf_ReadData2 = 64'h22;
    accept(32'h002081B3, 64'h1000);  // add x3,x1,x2
    check("add_rd", 400'(id_rd), 400'(3));
    check("add_imm", 400'(id_imm), 400'(0));
    check("add_ctl", 400'({id_RegWrite, id_MemRead, id_ALUSrc, id_ALUOp}), 400'(5'b10010));
    accept(32'h0080B283, 64'h1004);  // ld x5,8(x1)
    check("ld_rd", 400'(id_rd), 400'(5));
    check("ld_imm", 400'(id_imm), 400'(8));
    check("ld_ctl", 400'({id_RegWrite, id_MemRead, id_MemtoReg, id_ALUSrc, id_ALUOp}),
          400'(6'b111100));
    accept(32'hFE513E23, 64'h1008);  // sd x5,-4(x2)
    check("sd_imm", 400'(id_imm), 400'(64'hFFFF_FFFF_FFFF_FFFC));
    check("sd_ctl", 400'({id_MemWrite, id_RegWrite, id_ALUSrc}), 400'(3'b101));

    // Load-use: exactly one bubble.
    accept(32'h0000B283, 64'h2000);  // ld x5,0(x1)
    if_instr = 32'h00228333;         // add x6,x5,x2
    if_pc    = 64'h2004;
    tick();
    check("lu_stall_rdy", 400'(last_rdy), 400'(0));
    check("lu_bubble", 400'(id_valid), 400'(0));
    tick();
    check("lu_go_rdy", 400'(last_rdy), 400'(1));
    check("lu_add_rd", 400'({id_valid, id_rd}), 400'({1'b1, 5'd6}));
    // Load to x0: no bubble.
    accept(32'h0000B003, 64'h2008);  // ld x0,0(x1)
    if_instr = 32'h00200333;         // add x6,x0,x2
    if_pc    = 64'h200C;
    tick();
    check("x0_no_stall", 400'(last_rdy), 400'(1));

    // Backpressure.
    accept(32'h002081B3, 64'h3000);
    ex_ready = 1'b0;
    if_instr = 32'h00310213;  // addi x4,x2,3
    if_pc    = 64'h3004;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_rdy", 400'(last_rdy), 400'(0));
      check("bp_hold_pc", 400'({id_valid, id_pc}), 400'({1'b1, 64'h3000}));
    end
    ex_ready = 1'b1;
    tick();
    check("bp_release", 400'({id_pc, id_imm}), 400'({64'h3004, 64'd3}));

    // Flush.
    if_instr = 32'h002081B3;
    if_pc    = 64'h4000;
    flush    = 1'b1;
    tick();
    check("flush_rdy", 400'(last_rdy), 400'(0));
    check("flush_valid", 400'(id_valid), 400'(0));
    flush = 1'b0;
    tick();
    check("flush_after", 400'({id_valid, id_pc}), 400'({1'b1, 64'h4000}));

    // Write-back bypass on operand 1.
    wb_RegWrite = 1'b1; wb_rd = 5'd1; wb_WriteData = 64'h1234; rf_ReadData1 = '0;
    accept(32'h002081B3, 64'h5000);
`ifdef ID_WB_BYPASS_EN
    check("bypass_rd1", 400'(id_ReadData1), 400'(64'h1234));
`else
    check("bypass_rd1", 400'(id_ReadData1), 400'(0));
`endif
    wb_RegWrite = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [6:0]  ops [5];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
      ins = $urandom;
      if ($urandom_range(0, 5) != 0) ins[6:0] = ops[$urandom_range(0, 4)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      if_instr     = ins;
      if_pc        = {$urandom, $urandom};
      if_valid     = ($urandom_range(0, 4) != 0);
      ex_ready     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 9) == 0);
      rf_ReadData1 = {$urandom, $urandom};
      rf_ReadData2 = {$urandom, $urandom};
      wb_RegWrite  = 1'($urandom);
      wb_rd        = 5'($urandom_range(0, 3));
      wb_WriteData = {$urandom, $urandom};
      tick();
    end
    if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; wb_RegWrite = 1'b0;
    tick();

    // Reset during a stall, then a dependent instruction sees no stale hazard.
    accept(32'h0000B283, 64'h6000);  // ld x5,0(x1)
    ex_ready = 1'b0;
    if_instr = 32'h00228333;
    tick();
    #2 reset = 1'b0;
    #1;
    check("midreset_async", 400'(obs), 400'(0));
    m = '0;
    @(posedge clk);
    #1;
    check("midreset_hold", 400'(obs), 400'(0));
    #2 reset = 1'b1;
    ex_ready = 1'b1;
    if_instr = 32'h00228333;
    if_pc    = 64'h6004;
    tick();
    check("post_reset_rdy", 400'(last_rdy), 400'(1));
    check("post_reset_id", 400'({id_valid, id_pc}), 400'({1'b1, 64'h6004}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
